// File: rtl/mc_control.sv
// mc_control: multi-cycle control sequencer for the core's control bus.
//
// Fetches one instruction, decodes opcode/funct, then steps through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) while driving the control bus
// for that instruction alone. An unsupported encoding or a data memory
// that never answers parks the sequencer in TRAP until reset.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   instr, instr_valid    instruction word and its valid strobe (FETCH only)
//   mem_ready             data memory access complete (MEM only)
//   instr_req, ir_we      fetch request / IR load strobe
//   pc_we, pc_next        PC commit strobe and PC source select
//   reg_dst, reg_in       register write address / data source selects
//   reg_we, mem_we        register file / data memory write enables
//   alu_src, alu_ctrl     ALU operand B select and operation
//   beq, bne              branch qualifiers (core resolves taken/not-taken)
//   state                 current sequencer state
//   fault, fault_code     sticky fault flag and cause (01 illegal, 10 timeout)
//   retired_count         retired instruction count (0 unless enabled)
//
// Build option: define MC_CTRL_PERF_EN to implement the retired_count
// counter; otherwise the port is tied to zero.

module mc_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        mem_ready,
  output logic        instr_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_next,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic        reg_we,
  output logic [1:0]  reg_in,
  output logic        mem_we,
  output logic        beq,
  output logic        bne,
  output logic [2:0]  state,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_SLT, I_JR, I_ADDI, I_XORI, I_LW, I_SW,
    I_BEQ, I_BNE, I_J, I_JAL, I_ILL
  } iclass_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  // Last counter value before the timeout fires; counter starts at 0 on MEM entry.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          cur_state, nxt_state;
  iclass_t         icls;
  logic [5:0]      ir_op, ir_fn;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic [1:0]      fcode_q, fcode_d;

  // Only opcode and funct steer the sequencer; the rest belongs to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  // IR is a data capture, loaded only on the accepted fetch.
  always_ff @(posedge clk) begin
    if (ir_we) begin
      ir_op <= instr[31:26];
      ir_fn <= instr[5:0];
    end
  end

  always_comb begin
    icls = I_ILL;
    case (ir_op)
      6'h00: begin
        case (ir_fn)
          6'h20:   icls = I_ADD;
          6'h22:   icls = I_SUB;
          6'h2a:   icls = I_SLT;
          6'h08:   icls = I_JR;
          default: icls = I_ILL;
        endcase
      end
      6'h08:   icls = I_ADDI;
      6'h0e:   icls = I_XORI;
      6'h23:   icls = I_LW;
      6'h2b:   icls = I_SW;
      6'h04:   icls = I_BEQ;
      6'h05:   icls = I_BNE;
      6'h02:   icls = I_J;
      6'h03:   icls = I_JAL;
      default: icls = I_ILL;
    endcase
  end

  assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      to_cnt    <= '0;
      fcode_q   <= 2'b00;
    end else begin
      cur_state <= nxt_state;
      // Held at zero outside MEM so every MEM visit starts a fresh count.
      if (cur_state != S_MEM)
        to_cnt <= '0;
      else if (!mem_ready)
        to_cnt <= to_cnt + TO_W'(1);
      if (nxt_state == S_TRAP && cur_state != S_TRAP)
        fcode_q <= fcode_d;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    fcode_d   = 2'b00;
    instr_req = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_next   = 2'd0;
    reg_dst   = 2'd0;
    alu_src   = 1'b0;
    alu_ctrl  = ALU_ADD;
    reg_we    = 1'b0;
    reg_in    = 2'd0;
    mem_we    = 1'b0;
    beq       = 1'b0;
    bne       = 1'b0;
    case (cur_state)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          // Suppressed while reset is held so no IR load leaks out of reset.
          ir_we     = ~reset;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (icls == I_ILL) begin
          nxt_state = S_TRAP;
          fcode_d   = 2'b01;
        end else begin
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src = (icls == I_ADDI) || (icls == I_XORI) || (icls == I_LW) || (icls == I_SW);
        case (icls)
          I_SUB, I_BEQ, I_BNE: alu_ctrl = ALU_SUB;
          I_XORI:              alu_ctrl = ALU_XOR;
          I_SLT:               alu_ctrl = ALU_SLT;
          default:             alu_ctrl = ALU_ADD;
        endcase
        case (icls)
          I_BEQ: begin beq = 1'b1; pc_next = 2'd1; pc_we = 1'b1; nxt_state = S_FETCH; end
          I_BNE: begin bne = 1'b1; pc_next = 2'd1; pc_we = 1'b1; nxt_state = S_FETCH; end
          I_J:   begin pc_next = 2'd2; pc_we = 1'b1; nxt_state = S_FETCH; end
          I_JR:  begin pc_next = 2'd3; pc_we = 1'b1; nxt_state = S_FETCH; end
          I_LW, I_SW: nxt_state = S_MEM;
          default:    nxt_state = S_WB;
        endcase
      end
      S_MEM: begin
        alu_src  = 1'b1;
        alu_ctrl = ALU_ADD;
        mem_we   = (icls == I_SW);
        // A response on the limit cycle still completes the access.
        if (mem_ready) begin
          if (icls == I_SW) begin
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (to_hit) begin
          nxt_state = S_TRAP;
          fcode_d   = 2'b10;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        nxt_state = S_FETCH;
        case (icls)
          I_ADD, I_SUB, I_SLT: reg_dst = 2'd1;
          I_LW:                reg_in  = 2'd1;
          I_JAL: begin
            reg_dst = 2'd2;
            reg_in  = 2'd2;
            pc_next = 2'd2;
          end
          default: ;
        endcase
      end
      S_TRAP: nxt_state = S_TRAP;
      default: nxt_state = S_FETCH;
    endcase
  end

  assign state      = cur_state;
  assign fault      = (cur_state == S_TRAP);
  assign fault_code = (cur_state == S_TRAP) ? fcode_q : 2'b00;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired_q <= '0;
    else if (pc_we)
      retired_q <= retired_q + 32'd1;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic        clk, reset;
  logic [31:0] instr;
  logic        instr_valid, mem_ready;
  logic        instr_req, ir_we, pc_we, alu_src, reg_we, mem_we, beq, bne, fault;
  logic [1:0]  pc_next, reg_dst, reg_in, fault_code;
  logic [2:0]  alu_ctrl, state;
  logic [31:0] retired_count;

  mc_control #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .instr_req(instr_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_next(pc_next), .reg_dst(reg_dst), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .reg_we(reg_we), .reg_in(reg_in), .mem_we(mem_we), .beq(beq), .bne(bne),
    .state(state), .fault(fault), .fault_code(fault_code),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [22:0] vec;
    logic [31:0] rc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [22:0] mon_act;
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned rc_m   = 0;

  logic [22:0] V_F, V_FA, V_D, V_EZ, V_EI, V_TRAP1, V_TRAP2, V_MSW, V_MLW;

  // {state, instr_req, ir_we, pc_we, pc_next, reg_dst, alu_src, alu_ctrl,
  //  reg_we, reg_in, mem_we, beq, bne, fault, fault_code}
  function automatic logic [22:0] v(int st, int req, int irw, int pcw, int pcn,
                                    int rd, int as_, int ac, int rw, int ri,
                                    int mw, int bq, int bn, int f, int fc);
    return {3'(st), 1'(req), 1'(irw), 1'(pcw), 2'(pcn), 2'(rd), 1'(as_), 3'(ac),
            1'(rw), 2'(ri), 1'(mw), 1'(bq), 1'(bn), 1'(f), 2'(fc)};
  endfunction

  task automatic cyc(input logic iv, input logic mr, input logic rs,
                     input string nm, input logic [22:0] e);
    exp_t x;
    instr_valid = iv;
    mem_ready   = mr;
    reset       = rs;
    if (rs) rc_m = 0;
    x.name = nm;
    x.vec  = e;
`ifdef MC_CTRL_PERF_EN
    x.rc   = rc_m;
`else
    x.rc   = 32'd0;
`endif
    exp_q.push_back(x);
    if (e[17] && !rs) rc_m = rc_m + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input logic [31:0] w, input string nm);
    instr = w;
    cyc(1'b1, 1'b0, 1'b0, {nm, ".F"}, V_FA);
    cyc(1'b0, 1'b0, 1'b0, {nm, ".D"}, V_D);
  endtask

  task automatic br_instr(input logic [31:0] w, input string nm, input logic [22:0] ee);
    fd(w, nm);
    cyc(1'b0, 1'b0, 1'b0, {nm, ".E"}, ee);
  endtask

  task automatic wb_instr(input logic [31:0] w, input string nm,
                          input logic [22:0] ee, input logic [22:0] ew);
    br_instr(w, nm, ee);
    cyc(1'b0, 1'b0, 1'b0, {nm, ".WB"}, ew);
  endtask

  task automatic trap_then_reset(input string nm, input logic [22:0] et);
    cyc(1'b1, 1'b1, 1'b0, {nm, ".T0"}, et);
    cyc(1'b1, 1'b1, 1'b0, {nm, ".T1"}, et);
    cyc(1'b1, 1'b0, 1'b1, {nm, ".RST"}, V_F);
    cyc(1'b0, 1'b0, 1'b0, {nm, ".POST"}, V_F);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {state, instr_req, ir_we, pc_we, pc_next, reg_dst, alu_src, alu_ctrl,
                 reg_we, reg_in, mem_we, beq, bne, fault, fault_code};
      n_chk = n_chk + 1;
      if (mon_act !== mon_e.vec || retired_count !== mon_e.rc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got bus=%h rc=%0d, expected bus=%h rc=%0d",
                 mon_e.name, mon_act, retired_count, mon_e.vec, mon_e.rc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    V_F     = v(0,1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    V_FA    = v(0,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
    V_D     = v(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    V_EZ    = v(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    V_EI    = v(2,0,0,0,0,0,1,0,0,0,0,0,0,0,0);
    V_MSW   = v(3,0,0,0,0,0,1,0,0,0,1,0,0,0,0);
    V_MLW   = v(3,0,0,0,0,0,1,0,0,0,0,0,0,0,0);
    V_TRAP1 = v(7,0,0,0,0,0,0,0,0,0,0,0,0,1,1);
    V_TRAP2 = v(7,0,0,0,0,0,0,0,0,0,0,0,0,1,2);

    reset = 1'b1; instr = 32'h0; instr_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b1, "RESET", V_F);

    // ADD with instr_valid held high throughout
    instr = 32'h012A4020;
    cyc(1'b1, 1'b0, 1'b0, "ADD.F", V_FA);
    cyc(1'b1, 1'b0, 1'b0, "ADD.D", V_D);
    cyc(1'b1, 1'b0, 1'b0, "ADD.E", V_EZ);
    cyc(1'b1, 1'b0, 1'b0, "ADD.WB", v(4,0,0,1,0,1,0,0,1,0,0,0,0,0,0));
    cyc(1'b0, 1'b0, 1'b0, "IDLE.F", V_F);

    // LW: three MEM cycles, mem_ready on the third
    br_instr(32'h8D280004, "LW", V_EI);
    cyc(1'b0, 1'b0, 1'b0, "LW.M0", V_MLW);
    cyc(1'b0, 1'b0, 1'b0, "LW.M1", V_MLW);
    cyc(1'b0, 1'b1, 1'b0, "LW.M2", V_MLW);
    cyc(1'b0, 1'b0, 1'b0, "LW.WB", v(4,0,0,1,0,0,0,0,1,1,0,0,0,0,0));

    br_instr(32'h15090003, "BNE", v(2,0,0,1,1,0,0,1,0,0,0,0,1,0,0));
    cyc(1'b0, 1'b0, 1'b0, "BNE.F4", V_F);
    br_instr(32'h11090003, "BEQ", v(2,0,0,1,1,0,0,1,0,0,0,1,0,0,0));
    br_instr(32'h08000010, "J",   v(2,0,0,1,2,0,0,0,0,0,0,0,0,0,0));
    br_instr(32'h03E00008, "JR",  v(2,0,0,1,3,0,0,0,0,0,0,0,0,0,0));

    wb_instr(32'h0C000010, "JAL",  V_EZ, v(4,0,0,1,2,2,0,0,1,2,0,0,0,0,0));
    wb_instr(32'h012A4022, "SUB",  v(2,0,0,0,0,0,0,1,0,0,0,0,0,0,0), v(4,0,0,1,0,1,0,0,1,0,0,0,0,0,0));
    wb_instr(32'h012A402A, "SLT",  v(2,0,0,0,0,0,0,3,0,0,0,0,0,0,0), v(4,0,0,1,0,1,0,0,1,0,0,0,0,0,0));
    wb_instr(32'h39280005, "XORI", v(2,0,0,0,0,0,1,2,0,0,0,0,0,0,0), v(4,0,0,1,0,0,0,0,1,0,0,0,0,0,0));
    wb_instr(32'h21280004, "ADDI", V_EI, v(4,0,0,1,0,0,0,0,1,0,0,0,0,0,0));

    // SW completing on its first MEM cycle
    br_instr(32'hAD280004, "SWF", V_EI);
    cyc(1'b0, 1'b1, 1'b0, "SWF.M0", v(3,0,0,1,0,0,1,0,0,0,1,0,0,0,0));
    cyc(1'b0, 1'b0, 1'b0, "SWF.F", V_F);

    // SW whose mem_ready lands on the timeout limit cycle: no fault
    br_instr(32'hAD280004, "SWL", V_EI);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, $sformatf("SWL.M%0d", i), V_MSW);
    cyc(1'b0, 1'b1, 1'b0, "SWL.M15", v(3,0,0,1,0,0,1,0,0,0,1,0,0,0,0));
    cyc(1'b0, 1'b0, 1'b0, "SWL.F", V_F);

    // Illegal funct, then illegal opcode
    fd(32'h012A4021, "ILLF");
    trap_then_reset("ILLF", V_TRAP1);
    fd(32'hFC000000, "ILLOP");
    trap_then_reset("ILLOP", V_TRAP1);

    // SW timeout: 16 MEM cycles with mem_we, then TRAP code 10
    br_instr(32'hAD280004, "SWT", V_EI);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, $sformatf("SWT.M%0d", i), V_MSW);
    trap_then_reset("SWT", V_TRAP2);

    // Reset landing in MEM of a second SW clears mem_we at once
    br_instr(32'hAD280004, "SW2", V_EI);
    cyc(1'b0, 1'b0, 1'b0, "SW2.M0", V_MSW);
    cyc(1'b0, 1'b0, 1'b1, "SW2.RST", V_F);
    cyc(1'b0, 1'b0, 1'b0, "SW2.POST", V_F);

    @(negedge clk);
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control sequencer. It is the producer side of the core's control bus: pc_next, reg_dst, alu_src, alu_ctrl, reg_we, reg_in, mem_we, beq, bne.
- Fetches one instruction word and decodes opcode/funct.
- Steps through FETCH/DECODE/EXEC/MEM/WB, driving the control bus for exactly one instruction at a time.
- Sits between instruction memory, data memory handshake and the core datapath; the core resolves branch taken/not-taken from its own zero flag.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting in MEM for mem_ready before fault; 0 disables the timeout.
- TO_W, 5, width of timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr  input  32  instruction word from instruction memory
- instr_valid  input  1  instr is valid this cycle
- mem_ready  input  1  data memory completed access this cycle
- instr_req  output  1  fetch request, high in FETCH
- ir_we  output  1  latch instr into core IR; pulses on the accepted fetch
- pc_we  output  1  commit PC update; exactly one pulse per retired instruction
- pc_next  output  2  0=PC+4, 1=branch target, 2=jump addr, 3=regDataA (jr)
- reg_dst  output  2  0=rt, 1=rd, 2=$31
- alu_src  output  1  0=regDataB, 1=sign-extended imm
- alu_ctrl  output  3  0=ADD, 1=SUB, 2=XOR, 3=SLT
- reg_we  output  1  register file write, one-cycle pulse in WB
- reg_in  output  2  0=ALU, 1=memory, 2=PC+4
- mem_we  output  1  data memory write, held through MEM for SW
- beq  output  1  branch-if-equal qualifier
- bne  output  1  branch-if-not-equal qualifier
- state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
- fault  output  1  sticky fault flag
- fault_code  output  2  01=illegal opcode/funct, 10=memory timeout

Behaviour:
- Reset (async, immediate): state=FETCH, all outputs 0 except instr_req=1. No pulses are generated during reset. Reset mid-instruction abandons that instruction with no pc_we.
- IR holds opcode[31:26] and funct[5:0], captured on the FETCH handshake.
- FETCH: instr_req=1. On instr_valid: ir_we=1 for one cycle, go to DECODE. Otherwise stay.
- DECODE: classify the instruction.
  - Supported: R-type (op 0x00) with funct ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08; ADDI 0x08; XORI 0x0e; LW 0x23; SW 0x2b; BEQ 0x04; BNE 0x05; J 0x02; JAL 0x03.
  - Anything else goes to TRAP with fault_code=01.
- EXEC:
  - alu_src=1 for ADDI, XORI, LW, SW; else 0.
  - alu_ctrl: ADD for ADD/ADDI/LW/SW; SUB for SUB/BEQ/BNE; XOR for XORI; SLT for SLT.
  - BEQ/BNE: beq or bne=1, pc_next=1, pc_we=1, go to FETCH.
  - J: pc_next=2, pc_we=1, go to FETCH.
  - JR: pc_next=3, pc_we=1, go to FETCH.
  - LW/SW: go to MEM.
  - R-type ALU, ADDI, XORI, JAL: go to WB.
- MEM:
  - alu_ctrl=ADD and alu_src=1 held.
  - SW holds mem_we=1 until mem_ready.
  - On mem_ready: SW pulses pc_we (pc_next=0) and goes to FETCH; LW goes to WB.
  - Timeout counter clears on MEM entry and increments each cycle without mem_ready. Reaching MEM_TIMEOUT goes to TRAP with fault_code=10 and mem_we deasserted.
  - mem_ready arriving on the same cycle as the limit wins; no fault.
- WB: reg_we=1 and pc_we=1 for one cycle, then FETCH.
  - R-type: reg_dst=1, reg_in=0.
  - ADDI/XORI: reg_dst=0, reg_in=0.
  - LW: reg_dst=0, reg_in=1.
  - JAL: reg_dst=2, reg_in=2, pc_next=2.
  - pc_next=0 otherwise.
- TRAP: fault=1, all enables 0, instr_req=0. Stays in TRAP until reset.
- Outputs not named for a state are 0 in that state.
- Minimum latency (FETCH with instr_valid already high):
  - branch/J/JR: 3 cycles
  - ALU/JAL: 4 cycles
  - SW: 4 cycles
  - LW: 5 cycles
  - each mem_ready wait cycle adds 1
- instr_valid is ignored outside FETCH. mem_ready is ignored outside MEM.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined: adds output retired_count, 32 bits. It resets to 0, increments on every pc_we pulse, and wraps 0xFFFFFFFF to 0.
- Undefined: port is present but tied to 0 and no counter is synthesised.

Test Plan:
- Reset, then ADD (0x012A4020) with instr_valid held -> states 0,1,2,4. WB has reg_we=1, reg_dst=1, reg_in=0, pc_we=1. One ir_we pulse.
- LW (0x8D280004) with mem_ready delayed 3 cycles -> MEM lasts 3 cycles, alu_src=1, alu_ctrl=0. WB has reg_in=1, reg_dst=0. Total 7 cycles, single pc_we.
- BNE (0x15090003) -> EXEC has bne=1, beq=0, alu_ctrl=1, pc_next=1, pc_we=1. Back in FETCH on cycle 4.
- JAL (0x0C000010) -> EXEC has no pc_we. WB has reg_dst=2, reg_in=2, pc_next=2, reg_we=1, pc_we=1.
- Opcode 0x3F -> TRAP after DECODE, fault=1, fault_code=01. instr_valid ignored afterwards; reset returns to FETCH with fault=0.
- SW with mem_ready never asserted (MEM_TIMEOUT=16) -> mem_we high 16 cycles, then TRAP with fault_code=10, mem_we=0, no pc_we. Reset asserted in MEM of a second SW clears mem_we immediately.
